// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT layer scheduler.
package gat_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LOAD,
      RUN,
      DRAIN,
      NEXT,
      ERROR
   } state_t;

   // Feature word width and byte-address shift for 32-bit BRAM words.
   localparam int unsigned FEAT_W     = 32;
   localparam int unsigned ADDR_SHIFT = 2;

endpackage

// File: rtl/gat_feat_skid_fifo.sv
// Small synchronous FIFO that absorbs feature reads while the stream is stalled.
module gat_feat_skid_fifo #(
   parameter int unsigned DATA_W = 33,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DATA_W-1:0]      wdata,
   input  logic                   pop,
   output logic [DATA_W-1:0]      rdata,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Storage array; no reset needed since empty masks stale contents.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/gat_layer_scheduler.sv
// Sequences the GAT core through its layers and drains each layer's features onto a stream.
module gat_layer_scheduler
   import gat_pkg::*;
#(
   parameter int unsigned NUM_LAYERS     = 2,
   parameter int unsigned FEAT_WORDS_L0  = 43328,
   parameter int unsigned FEAT_WORDS_L1  = 18956,
   parameter int unsigned FEAT_ADDR_W    = 18,
   parameter int unsigned RD_LAT         = 2,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   h_data_load_done,
   input  logic                   h_node_load_done,
   input  logic                   wgt_load_done,
   output logic                   gat_layer,
   input  logic                   gat_ready,
   output logic                   reload_req,
   output logic [FEAT_ADDR_W-1:0] feat_bram_addrb,
   input  logic [FEAT_W-1:0]      feat_bram_dout,
   output logic [FEAT_W-1:0]      feat_tdata,
   output logic                   feat_tvalid,
   input  logic                   feat_tready,
   output logic                   feat_tlast,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err
);

   localparam int unsigned MAX_WORDS = (FEAT_WORDS_L0 > FEAT_WORDS_L1) ? FEAT_WORDS_L0
                                                                      : FEAT_WORDS_L1;
   localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   // Wide enough for FIFO occupancy plus up to four reads in flight.
   localparam int unsigned OCC_W = CNT_W + 3;

   state_t            state;
   logic              layer;
   logic              gat_ready_q;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [IDX_W-1:0]  word_idx;
   logic [IDX_W-1:0]  n_words;
   logic [RD_LAT-1:0] vld_pipe;
   logic [RD_LAT-1:0] last_pipe;
   logic [OCC_W-1:0]  in_flight;
   logic [OCC_W-1:0]  occupancy;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic [FEAT_W:0]   fifo_wdata;
   logic [FEAT_W:0]   fifo_rdata;
   logic              issue;
   logic              issue_last;
   logic              pop;
   logic              last_pop;
   logic              gat_rise;
   logic              layers_left;
   logic              loads_done;

   assign n_words     = layer ? IDX_W'(FEAT_WORDS_L1) : IDX_W'(FEAT_WORDS_L0);
   assign gat_rise    = gat_ready && !gat_ready_q;
   assign layers_left = (32'(layer) + 32'd1) < NUM_LAYERS;
   assign loads_done  = h_data_load_done && h_node_load_done && wgt_load_done;

   assign pop             = !fifo_empty && feat_tready;
   assign last_pop        = pop && fifo_rdata[FEAT_W];
   assign feat_tvalid     = !fifo_empty;
   assign feat_tdata      = fifo_empty ? '0 : fifo_rdata[FEAT_W-1:0];
   assign feat_tlast      = !fifo_empty && fifo_rdata[FEAT_W];
   assign feat_bram_addrb = FEAT_ADDR_W'(word_idx) << ADDR_SHIFT;
   assign busy            = (state != IDLE) && (state != ERROR);
   assign gat_layer       = layer;
   assign fifo_wdata      = {last_pipe[RD_LAT-1], feat_bram_dout};

   // Credit check: a read issues only if its data is guaranteed a FIFO slot on arrival.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
         in_flight = in_flight + OCC_W'(vld_pipe[i]);
      end
      occupancy  = OCC_W'(fifo_count) + in_flight;
      issue      = (state == DRAIN) && (word_idx < n_words) &&
                   (occupancy < OCC_W'(FIFO_DEPTH));
      issue_last = (word_idx == n_words - IDX_W'(1));
   end

   // Valid and last-tag shift registers that track each read through the BRAM latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         vld_pipe[0]  <= issue;
         last_pipe[0] <= issue && issue_last;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
         end
      end
   end

   // Layer sequencing FSM with registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         layer       <= 1'b0;
         gat_ready_q <= 1'b0;
         tmo_cnt     <= '0;
         word_idx    <= '0;
         reload_req  <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         gat_ready_q <= gat_ready;
         reload_req  <= 1'b0;
         done        <= 1'b0;
         if (issue) word_idx <= word_idx + IDX_W'(1);
         unique case (state)
            IDLE, ERROR: begin
               if (start) begin
                  state       <= WAIT_LOAD;
                  layer       <= 1'b0;
                  timeout_err <= 1'b0;
               end
            end
            WAIT_LOAD: begin
               if (loads_done) begin
                  state   <= RUN;
                  tmo_cnt <= '0;
               end
            end
            RUN: begin
               if (gat_rise) begin
                  state    <= DRAIN;
                  word_idx <= '0;
               end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  state       <= ERROR;
                  timeout_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            DRAIN: begin
               if (last_pop) begin
                  if (layers_left) begin
                     state      <= NEXT;
                     reload_req <= 1'b1;
                  end else begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            NEXT: begin
               state <= WAIT_LOAD;
               layer <= layer + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   gat_feat_skid_fifo #(
      .DATA_W (FEAT_W + 1),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vld_pipe[RD_LAT-1]),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule
